// File: rtl/psk8_pkg.sv
// Shared types and symbol constants for the 8-PSK frame scheduler.
package psk8_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2
  } sched_state_t;

  // Mapper null code: I=Q=0 between frames and on starved payload slots.
  localparam logic [3:0] PSK8_NULL_SYM = 4'b1000;
  localparam logic [2:0] PSK8_PRE_EVEN = 3'b000;  // 0 deg
  localparam logic [2:0] PSK8_PRE_ODD  = 3'b110;  // 180 deg

  // Wrap a 3-bit Gray symbol into the 4-bit mapper code.
  function automatic logic [3:0] psk8_code(input logic [2:0] s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/psk8_bit_packer.sv
// Byte-to-tribit packer: 11-bit left-aligned accumulator, oldest bit at [10].
module psk8_bit_packer
  import psk8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       pop,
  output logic [2:0] pop_data,
  output logic       pop_ok,
  input  logic       flush
);

  logic [10:0] acc;
  logic [3:0]  bit_cnt;
  logic        accept;

  // Accept only with room for a full byte; this also makes accept and a
  // successful pop mutually exclusive (bit_cnt < 3 vs bit_cnt >= 3).
  assign in_ready = enable && (bit_cnt < 4'd3);
  assign accept   = in_valid && in_ready;
  assign pop_ok   = (bit_cnt >= 4'd3);
  assign pop_data = acc[10:8];

  // Accumulator update: flush/reset clears, pop shifts out the top 3 bits,
  // an accepted byte lands directly below the bits already held.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (pop && pop_ok) begin
      acc     <= {acc[7:0], 3'b000};
      bit_cnt <= bit_cnt - 4'd3;
    end else if (accept) begin
      acc     <= acc | ({in_data, 3'b000} >> bit_cnt);
      bit_cnt <= bit_cnt + 4'd8;
    end
  end

endmodule

// File: rtl/psk8_frame_scheduler.sv
// Frame sequencer: preamble then payload tribits, one symbol every SPS clocks.
module psk8_frame_scheduler
  import psk8_pkg::*;
#(
  parameter int SPS          = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int FRAME_SYMS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] sym_out,
  output logic       sym_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow
);

  localparam int SW   = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int MAXS = (PREAMBLE_LEN > FRAME_SYMS) ? PREAMBLE_LEN : FRAME_SYMS;
  localparam int CW   = $clog2(MAXS + 1);

  sched_state_t  state, state_nxt;
  logic [SW-1:0] sps_cnt, sps_nxt;
  logic [CW-1:0] sym_cnt, cnt_nxt;
  logic [3:0]    sym_nxt, pay_sym;
  logic          vld_nxt, done_nxt, uf_nxt;
  logic          tick, pre_last, pay_last, pop, flush;
  logic [2:0]    pop_data;
  logic          pop_ok;

  assign busy     = (state != IDLE);
  assign tick     = busy && (sps_cnt == SW'(SPS - 1));
  // sym_cnt holds the number of symbols already issued in the current phase.
  assign pre_last = (sym_cnt == CW'(PREAMBLE_LEN));
  assign pay_last = (sym_cnt == CW'(FRAME_SYMS));
  assign pop      = tick && (((state == PREAMBLE) && pre_last) ||
                             ((state == PAYLOAD) && !pay_last));
  assign flush    = abort || (tick && (state == PAYLOAD) && pay_last);
  assign pay_sym  = pop_ok ? psk8_code(pop_data) : PSK8_NULL_SYM;

  psk8_bit_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .enable   (busy),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pop      (pop),
    .pop_data (pop_data),
    .pop_ok   (pop_ok),
    .flush    (flush)
  );

  // Next-state and next-output decode. The start cycle itself acts as the
  // first symbol tick, so preamble symbol 0 is registered straight from IDLE
  // and the SPS counter restarts at 0 behind it.
  always_comb begin
    state_nxt = state;
    sps_nxt   = busy ? (tick ? '0 : sps_cnt + 1'b1) : '0;
    cnt_nxt   = sym_cnt;
    sym_nxt   = sym_out;
    vld_nxt   = 1'b0;
    done_nxt  = 1'b0;
    uf_nxt    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      sps_nxt   = '0;
      cnt_nxt   = '0;
      sym_nxt   = PSK8_NULL_SYM;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt = PREAMBLE;
          cnt_nxt   = CW'(1);
          sym_nxt   = psk8_code(PSK8_PRE_EVEN);
          vld_nxt   = 1'b1;
        end
        PREAMBLE: if (tick) begin
          vld_nxt = 1'b1;
          if (pre_last) begin
            state_nxt = PAYLOAD;
            cnt_nxt   = CW'(1);
            sym_nxt   = pay_sym;
            uf_nxt    = !pop_ok;
          end else begin
            cnt_nxt = sym_cnt + 1'b1;
            sym_nxt = psk8_code(sym_cnt[0] ? PSK8_PRE_ODD : PSK8_PRE_EVEN);
          end
        end
        PAYLOAD: if (tick) begin
          vld_nxt = 1'b1;
          if (pay_last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sym_nxt   = PSK8_NULL_SYM;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = sym_cnt + 1'b1;
            sym_nxt = pay_sym;
            uf_nxt  = !pop_ok;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sps_cnt    <= '0;
      sym_cnt    <= '0;
      sym_out    <= PSK8_NULL_SYM;
      sym_valid  <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sps_cnt    <= sps_nxt;
      sym_cnt    <= cnt_nxt;
      sym_out    <= sym_nxt;
      sym_valid  <= vld_nxt;
      frame_done <= done_nxt;
      underflow  <= uf_nxt;
    end
  end

endmodule

// File: tb/tb_psk8_frame_scheduler.sv
// Directed, table-driven bench for psk8_frame_scheduler.
module tb_psk8_frame_scheduler;

  localparam logic [3:0] NUL = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       a_rdy, a_vld, a_busy, a_done, a_uf;
  logic [3:0] a_sym;
  logic       b_rdy, b_vld, b_busy, b_done, b_uf;
  logic [3:0] b_sym;

  always #5 clk = ~clk;

  psk8_frame_scheduler #(.SPS(4), .PREAMBLE_LEN(8), .FRAME_SYMS(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_rdy),
    .sym_out(a_sym), .sym_valid(a_vld), .busy(a_busy),
    .frame_done(a_done), .underflow(a_uf));

  psk8_frame_scheduler #(.SPS(2), .PREAMBLE_LEN(8), .FRAME_SYMS(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_rdy),
    .sym_out(b_sym), .sym_valid(b_vld), .busy(b_busy),
    .frame_done(b_done), .underflow(b_uf));

  // Expected outputs at cycle r after the scenario origin (r=0 is the start
  // cycle); exp packs {sym_out, sym_valid, frame_done, underflow, busy}.
  typedef struct {
    int         r;
    logic [7:0] exp;
    int         ir;   // expected in_ready, -1 = not checked
  } vec_t;

  vec_t       tbl[$];
  int         checks = 0, failures = 0;
  int         sel = 0, s_a = -1, s_b = -1, ab_r = -1, rs_r = -1, nbytes = 0;
  int         avail[3] = '{0, 0, 0};
  logic [7:0] bytes[3] = '{8'h05, 8'h39, 8'h77};

  task automatic ex(input int r, input logic [3:0] s, input logic v,
                    input logic d, input logic u, input logic b, input int ir = -1);
    vec_t e;
    e.r = r; e.exp = {s, v, d, u, b}; e.ir = ir;
    tbl.push_back(e);
  endtask

  task automatic cfg(input int sl, input int sa, input int sb, input int ab,
                     input int rs, input int nb, input int av1);
    sel = sl; s_a = sa; s_b = sb; ab_r = ab; rs_r = rs; nbytes = nb;
    avail[0] = 0; avail[1] = av1; avail[2] = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full frame with bytes 05 39 77 streamed in: 8 alternating preamble
  // symbols, payload 000..111, then the null completion symbol.
  task automatic fill_full();
    ex(0, NUL, 0, 0, 0, 0, 0);
    ex(1, 4'b0000, 1, 0, 0, 1, 1);
    ex(2, 4'b0000, 0, 0, 0, 1, 0);
    ex(5, 4'b0110, 1, 0, 0, 1);
    ex(29, 4'b0110, 1, 0, 0, 1);
    ex(32, 4'b0110, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] s3;
      s3 = k[2:0];
      ex(33 + 4 * k, {1'b0, s3}, 1, 0, 0, 1);
    end
    ex(65, NUL, 1, 1, 0, 0);
    ex(66, NUL, 0, 0, 0, 0, 0);
  endtask

  task automatic run(input string name, input int ncyc);
    int         acc;
    logic [7:0] act;
    logic       rdy;
    acc = 0;
    for (int r = 0; r <= ncyc; r++) begin
      @(negedge clk);
      act = sel ? {b_sym, b_vld, b_done, b_uf, b_busy}
                : {a_sym, a_vld, a_done, a_uf, a_busy};
      rdy = sel ? b_rdy : a_rdy;
      foreach (tbl[i]) begin
        if (tbl[i].r == r) begin
          checks++;
          if (act !== tbl[i].exp) begin
            failures++;
            $display("FAIL %s r=%0d sym/vld/done/uf/busy actual=%b required=%b",
                     name, r, act, tbl[i].exp);
          end
          if (tbl[i].ir >= 0) begin
            checks++;
            if (rdy !== (tbl[i].ir != 0)) begin
              failures++;
              $display("FAIL %s r=%0d in_ready actual=%b required=%0d",
                       name, r, rdy, tbl[i].ir);
            end
          end
        end
      end
      start = (r == s_a) || (r == s_b);
      abort = (r == ab_r);
      rst   = (r == rs_r);
      if (acc < nbytes && r >= avail[acc]) begin
        in_valid = 1'b1;
        in_data  = bytes[acc];
      end else begin
        in_valid = 1'b0;
      end
      // in_ready only moves on a clock edge, so this handshake is final.
      if (in_valid && rdy) acc++;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; in_valid = 1'b0;
    tbl.delete();
  endtask

  initial begin
    // 1: full frame from reset
    reset_dut();
    cfg(0, 0, -1, -1, -1, 3, 0);
    fill_full();
    run("full_frame", 70);

    // 2: second byte withheld until after payload symbol 2
    reset_dut();
    cfg(0, 0, -1, -1, -1, 3, 41);
    ex(33, 4'b0000, 1, 0, 0, 1);
    ex(37, 4'b0001, 1, 0, 0, 1);
    ex(41, NUL, 1, 0, 1, 1, 1);
    ex(42, NUL, 0, 0, 0, 1);
    ex(45, 4'b0010, 1, 0, 0, 1);
    ex(49, 4'b0011, 1, 0, 0, 1);
    ex(53, 4'b0100, 1, 0, 0, 1);
    ex(57, 4'b0101, 1, 0, 0, 1);
    ex(61, 4'b0110, 1, 0, 0, 1);
    ex(65, NUL, 1, 1, 0, 0);
    ex(66, NUL, 0, 0, 0, 0, 0);
    run("starve", 70);
    // residual 3 bits must be gone: next frame starts from fresh data
    cfg(0, 0, -1, -1, -1, 3, 0);
    fill_full();
    run("after_starve", 70);

    // 3: abort during payload symbol 4, then a clean frame without reset
    reset_dut();
    cfg(0, 0, -1, 50, -1, 3, 0);
    ex(49, 4'b0100, 1, 0, 0, 1);
    ex(51, NUL, 0, 0, 0, 0, 0);
    ex(65, NUL, 0, 0, 0, 0, 0);
    run("abort", 70);
    cfg(0, 0, -1, -1, -1, 3, 0);
    fill_full();
    run("after_abort", 70);

    // 4: start while busy is ignored, reset mid-preamble
    reset_dut();
    cfg(0, 0, 6, -1, 14, 3, 0);
    ex(5, 4'b0110, 1, 0, 0, 1);
    ex(7, 4'b0110, 0, 0, 0, 1);
    ex(9, 4'b0000, 1, 0, 0, 1);
    ex(13, 4'b0110, 1, 0, 0, 1);
    ex(15, NUL, 0, 0, 0, 0, 0);
    ex(20, NUL, 0, 0, 0, 0, 0);
    run("busy_start_rst", 22);
    // start and abort together in IDLE
    cfg(0, 0, -1, 0, -1, 3, 0);
    ex(1, NUL, 0, 0, 0, 0, 0);
    ex(3, NUL, 0, 0, 0, 0, 0);
    run("start_abort", 5);

    // 5: SPS=2 back-to-back frames, no data (every payload slot starves)
    reset_dut();
    cfg(1, 0, 33, -1, -1, 0, 0);
    ex(1, 4'b0000, 1, 0, 0, 1);
    ex(2, 4'b0000, 0, 0, 0, 1);
    ex(3, 4'b0110, 1, 0, 0, 1);
    ex(15, 4'b0110, 1, 0, 0, 1);
    ex(17, NUL, 1, 0, 1, 1);
    ex(31, NUL, 1, 0, 1, 1);
    ex(32, NUL, 0, 0, 0, 1);
    ex(33, NUL, 1, 1, 0, 0);
    ex(34, 4'b0000, 1, 0, 0, 1);
    ex(35, 4'b0000, 0, 0, 0, 1);
    ex(36, 4'b0110, 1, 0, 0, 1);
    ex(64, NUL, 1, 0, 1, 1);
    ex(65, NUL, 0, 0, 0, 1);
    ex(66, NUL, 1, 1, 0, 0);
    run("back_to_back", 68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
